// File: rtl/snail_pattern_tx.sv
// Serial pattern transmitter: loads a word over a valid/ready handshake and shifts
// it out MSB-first on a, with optional back-to-back frames or a fixed idle gap.
module snail_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0] len_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             a,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_gap;
    logic             r_a;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_gap_nxt;
    logic             w_a_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    logic [CNT_W-1:0] w_len;
    logic [WIDTH-1:0] w_aligned;
    logic             w_last;
    logic             w_load;

    // r_cnt counts bits still to show, including the one currently on a.
    assign w_last     = (r_state == S_SEND) && (r_cnt == CNT_W'(1));
    assign load_ready = (r_state == S_IDLE) || ((GAP == 0) && w_last);
    assign w_load     = load_valid && load_ready;

    assign w_len     = ((len_in == '0) || (len_in > CNT_W'(WIDTH))) ? CNT_W'(WIDTH) : len_in;
    assign w_aligned = data_in << (CNT_W'(WIDTH) - w_len);

    // NOTE: combinational block uses blocking '=' and assigns every output a
    // default first, so no path through the case can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        w_a_nxt     = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;

        if (w_load) begin
            // First bit goes straight to the output register; the rest wait in the shifter.
            w_state_nxt = S_SEND;
            w_a_nxt     = w_aligned[WIDTH-1];
            w_shift_nxt = w_aligned << 1;
            w_cnt_nxt   = w_len;
            w_busy_nxt  = 1'b1;
            w_done_nxt  = (w_len == CNT_W'(1));
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_IDLE;
                end
                S_SEND: begin
                    if (!w_last) begin
                        w_a_nxt     = r_shift[WIDTH-1];
                        w_shift_nxt = r_shift << 1;
                        w_cnt_nxt   = r_cnt - CNT_W'(1);
                        w_busy_nxt  = 1'b1;
                        w_done_nxt  = (r_cnt == CNT_W'(2));
                    end else if (GAP > 0) begin
                        w_state_nxt = S_GAP;
                        w_gap_nxt   = 4'(GAP);
                        w_cnt_nxt   = '0;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                S_GAP: begin
                    if (r_gap == 4'd1) begin
                        w_state_nxt = S_IDLE;
                        w_gap_nxt   = '0;
                    end else begin
                        w_gap_nxt  = r_gap - 4'd1;
                        w_busy_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_a     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gap   <= w_gap_nxt;
            r_a     <= w_a_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign a    = r_a;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_snail_pattern_tx.sv
// Directed bench for snail_pattern_tx: one instance with GAP=0 (back-to-back)
// and one with GAP=2, each checked cycle by cycle against hand-computed streams.
module tb_snail_pattern_tx;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, v0, rdy0, a0, busy0, done0;
    logic [7:0] d0;
    logic [3:0] l0;
    logic       rst2, v2, rdy2, a2, busy2, done2;
    logic [7:0] d2;
    logic [3:0] l2;

    int n_cmp = 0;
    int n_err = 0;

    snail_pattern_tx #(.WIDTH(8), .CNT_W(4), .GAP(0)) u_gap0 (
        .clk(clk), .reset(rst0), .data_in(d0), .len_in(l0), .load_valid(v0),
        .load_ready(rdy0), .a(a0), .busy(busy0), .done(done0)
    );

    snail_pattern_tx #(.WIDTH(8), .CNT_W(4), .GAP(2)) u_gap2 (
        .clk(clk), .reset(rst2), .data_in(d2), .len_in(l2), .load_valid(v2),
        .load_ready(rdy2), .a(a2), .busy(busy2), .done(done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One GAP=0 frame; bits holds the expected stream left-aligned (bits[7] first).
    task automatic run0(input string name, input logic [7:0] data, input logic [3:0] len,
                        input logic [7:0] bits, input int n);
        check($sformatf("%s ready_c0", name), rdy0, 1);
        d0 = data; l0 = len; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s a_c%0d", name, i + 1), a0, bits[7-i]);
            check($sformatf("%s done_c%0d", name, i + 1), done0, (i == n - 1));
            check($sformatf("%s busy_c%0d", name, i + 1), busy0, 1);
            check($sformatf("%s ready_c%0d", name, i + 1), rdy0, (i == n - 1));
            tick();
        end
        check($sformatf("%s a_idle", name), a0, 0);
        check($sformatf("%s busy_idle", name), busy0, 0);
        check($sformatf("%s done_idle", name), done0, 0);
        check($sformatf("%s ready_idle", name), rdy0, 1);
    endtask

    initial begin
        logic [6:0] b2b;
        logic [3:0] g_a;
        logic [5:0] g5_a;

        rst0 = 1'b1; v0 = 1'b0; d0 = '0; l0 = '0;
        rst2 = 1'b1; v2 = 1'b0; d2 = '0; l2 = '0;
        tick();
        tick();
        rst0 = 1'b0; rst2 = 1'b0;
        check("rst a", a0, 0);
        check("rst busy", busy0, 0);
        check("rst done", done0, 0);
        check("rst ready", rdy0, 1);
        check("rst2 ready", rdy2, 1);
        check("rst2 busy", busy2, 0);

        // Single frames, including length clamping and ignored upper bits.
        run0("f1101", 8'b0000_1101, 4'd4, 8'b1101_0000, 4);
        run0("len0", 8'hA5, 4'd0, 8'hA5, 8);
        run0("len12", 8'hA5, 4'd12, 8'hA5, 8);
        run0("len1", 8'h01, 4'd1, 8'b1000_0000, 1);
        run0("upper", 8'hF0, 4'd3, 8'h00, 3);
        run0("len8", 8'h3C, 4'd8, 8'h3C, 8);

        // Back-to-back: second frame loaded in the last-bit cycle of the first.
        b2b = 7'b1101110;
        d0 = 8'h0D; l0 = 4'd4; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            check($sformatf("b2b a_c%0d", c), a0, b2b[7-c]);
            check($sformatf("b2b done_c%0d", c), done0, (c == 4 || c == 7));
            check($sformatf("b2b busy_c%0d", c), busy0, 1);
            check($sformatf("b2b ready_c%0d", c), rdy0, (c == 4 || c == 7));
            if (c == 4) begin
                d0 = 8'h06; l0 = 4'd3; v0 = 1'b1;
            end
            tick();
            v0 = 1'b0;
        end
        check("b2b busy_end", busy0, 0);
        check("b2b a_end", a0, 0);

        // Reset during bit 2 abandons the frame.
        d0 = 8'hA5; l0 = 4'd8; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        check("midrst a_c1", a0, 1);
        tick();
        check("midrst a_c2", a0, 0);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        check("midrst a", a0, 0);
        check("midrst busy", busy0, 0);
        check("midrst ready", rdy0, 1);
        check("midrst done", done0, 0);
        for (int c = 0; c < 8; c++) begin
            tick();
            check($sformatf("midrst quiet_done_%0d", c), done0, 0);
            check($sformatf("midrst quiet_a_%0d", c), a0, 0);
        end

        // Load together with reset: reset wins.
        rst0 = 1'b1; v0 = 1'b1; d0 = 8'hFF; l0 = 4'd8;
        tick();
        rst0 = 1'b0; v0 = 1'b0;
        check("rstload busy_c1", busy0, 0);
        check("rstload a_c1", a0, 0);
        tick();
        check("rstload busy_c2", busy0, 0);
        check("rstload a_c2", a0, 0);

        // GAP=2: two queued 2'b11 frames, valid held until accepted.
        g_a = 4'b1100;
        d2 = 8'h03; l2 = 4'd2; v2 = 1'b1;
        tick();
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("gap f1 a_c%0d", c), a2, g_a[4-c]);
            check($sformatf("gap f1 busy_c%0d", c), busy2, 1);
            check($sformatf("gap f1 ready_c%0d", c), rdy2, 0);
            check($sformatf("gap f1 done_c%0d", c), done2, (c == 2));
            tick();
        end
        check("gap idle a", a2, 0);
        check("gap idle busy", busy2, 0);
        check("gap idle ready", rdy2, 1);
        tick();
        v2 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("gap f2 a_c%0d", c), a2, g_a[4-c]);
            check($sformatf("gap f2 busy_c%0d", c), busy2, 1);
            check($sformatf("gap f2 ready_c%0d", c), rdy2, 0);
            check($sformatf("gap f2 done_c%0d", c), done2, (c == 2));
            tick();
        end
        check("gap end busy", busy2, 0);
        check("gap end ready", rdy2, 1);

        // GAP=2: a load of 8'hFF offered during SEND/GAP is ignored.
        g5_a = 6'b101000;
        d2 = 8'h0A; l2 = 4'd4; v2 = 1'b1;
        tick();
        d2 = 8'hFF; l2 = 4'd8;
        for (int c = 1; c <= 6; c++) begin
            check($sformatf("ign a_c%0d", c), a2, g5_a[6-c]);
            check($sformatf("ign busy_c%0d", c), busy2, 1);
            check($sformatf("ign ready_c%0d", c), rdy2, 0);
            check($sformatf("ign done_c%0d", c), done2, (c == 4));
            if (c == 6) v2 = 1'b0;
            tick();
        end
        check("ign idle busy", busy2, 0);
        check("ign idle a", a2, 0);
        tick();
        check("ign quiet busy", busy2, 0);
        check("ign quiet a", a2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
